// File: rtl/ysyx_22050133_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_22050133_pkg : shared core defines (ALU/CSR opcodes, hazard FSM codes)
// Rev 1.0 - initial release
// ============================================================================
package ysyx_22050133_pkg;

   localparam logic [3:0] ALUOP_ADD  = 4'd0;
   localparam logic [3:0] ALUOP_SUB  = 4'd1;
   localparam logic [3:0] ALUOP_AND  = 4'd2;
   localparam logic [3:0] ALUOP_OR   = 4'd3;
   localparam logic [3:0] ALUOP_XOR  = 4'd4;
   localparam logic [3:0] ALUOP_SLL  = 4'd5;
   localparam logic [3:0] ALUOP_SRL  = 4'd6;
   localparam logic [3:0] ALUOP_SRA  = 4'd7;

   localparam logic [1:0] CSROP_NONE = 2'd0;
   localparam logic [1:0] CSROP_RW   = 2'd1;
   localparam logic [1:0] CSROP_RS   = 2'd2;
   localparam logic [1:0] CSROP_RC   = 2'd3;

   localparam logic [1:0] HZ_RUN     = 2'd0;
   localparam logic [1:0] HZ_MD_WAIT = 2'd1;
   localparam logic [1:0] HZ_MD_HOLD = 2'd2;

   localparam int MD_TIMEOUT_DEF = 70;

   // x0 is never a real dependency, so it never reads as live.
   function automatic logic reg_live(input logic [4:0] r, input logic [31:0] pend);
      return (r != 5'd0) && pend[r];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050133_scoreboard.sv
`default_nettype none
// ============================================================================
// ysyx_22050133_scoreboard : in-flight destination tracking and RAW/WAW lookup
// Rev 1.0 - initial release
// ============================================================================
module ysyx_22050133_scoreboard
   import ysyx_22050133_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_id_valid,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic        i_wen,
   input  logic        i_issue,
   input  logic        i_clr_en,
   input  logic [4:0]  i_clr_rd,
   output logic [31:0] o_pending,
   output logic        o_raw
);

   logic [31:0] r_pending;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_issue && i_wen && (i_rd != 5'd0)) w_set_mask[i_rd] = 1'b1;
      if (i_clr_en) w_clr_mask[i_clr_rd] = 1'b1;
   end

   // Set is OR-ed in after the clear so a same-cycle retire/issue keeps the bit.
   always_ff @(posedge clk) begin
      if (rst) r_pending <= '0;
      else     r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
   end

   assign o_raw = i_id_valid & (reg_live(i_rs1, r_pending) |
                                reg_live(i_rs2, r_pending) |
                                (i_wen & reg_live(i_rd, r_pending)));
   assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050133_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// ysyx_22050133_hazard_ctrl : pipeline stall/flush control, MDU handshake FSM
// Rev 1.0 - initial release
// ============================================================================
module ysyx_22050133_hazard_ctrl
   import ysyx_22050133_pkg::*;
#(
   parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_wen,
   input  logic        ex_muldiv,
   input  logic        md_done,
   input  logic        mem_busy,
   input  logic        ex_redirect,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd,
   output logic        has_hazard,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        md_start,
   output logic        mem_bubble,
   output logic        md_timeout,
   output logic [31:0] pending
);

   localparam int CW = $clog2(MD_TIMEOUT + 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_md_start;
   logic          w_raw;
   logic          w_fsm_hold;
   logic          w_timeout;
   logic          w_issue;

   // w_fsm_hold is the MDU's own demand on IF/ID/EX; mem_busy is OR-ed on top.
   always_comb begin
      w_fsm_hold  = 1'b0;
      w_timeout   = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         HZ_RUN: begin
            w_fsm_hold = ex_muldiv;
            if (ex_muldiv && !mem_busy) w_state_nxt = HZ_MD_WAIT;
         end
         HZ_MD_WAIT: begin
            if (md_done) begin
               w_state_nxt = mem_busy ? HZ_MD_HOLD : HZ_RUN;
            end else if (r_cnt == CW'(MD_TIMEOUT)) begin
               w_timeout   = 1'b1;
               w_state_nxt = HZ_RUN;
            end else begin
               w_fsm_hold = 1'b1;
            end
         end
         HZ_MD_HOLD: begin
            if (!mem_busy) w_state_nxt = HZ_RUN;
         end
         default: w_state_nxt = HZ_RUN;
      endcase
   end

   // r_cnt holds k during the k-th MD_WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HZ_RUN;
         r_cnt      <= '0;
         r_md_start <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_md_start <= (r_state == HZ_RUN) && ex_muldiv && !mem_busy;
         if (r_state == HZ_RUN)          r_cnt <= CW'(1);
         else if (r_state == HZ_MD_WAIT) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign ex_stall   = mem_busy | w_fsm_hold;
   assign mem_stall  = mem_busy;
   assign mem_bubble = ex_stall;
   assign has_hazard = w_raw & ~ex_stall & ~ex_redirect;
   assign if_stall   = ex_stall | has_hazard;
   assign id_stall   = ex_stall | has_hazard;
   assign if_flush   = ex_redirect & ~ex_stall;
   assign id_flush   = ex_redirect & ~ex_stall;
   assign md_start   = r_md_start;
   assign md_timeout = w_timeout & ~rst;
   assign w_issue    = id_valid & ~w_raw & ~if_stall & ~ex_redirect;

   ysyx_22050133_scoreboard u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_id_valid (id_valid),
      .i_rs1      (id_rs1),
      .i_rs2      (id_rs2),
      .i_rd       (id_rd),
      .i_wen      (id_wen),
      .i_issue    (w_issue),
      .i_clr_en   (wb_wen),
      .i_clr_rd   (wb_rd),
      .o_pending  (pending),
      .o_raw      (w_raw)
   );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ysyx_22050133_hazard_ctrl : directed + random bench against a cycle model
// Rev 1.0 - initial release
// ============================================================================
module tb_ysyx_22050133_hazard_ctrl;

   localparam int T = 70;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_wen, ex_muldiv, md_done, mem_busy, ex_redirect, wb_wen;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        has_hazard, if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, md_start, mem_bubble, md_timeout;
   logic [31:0] pending;

   always #5 clk = ~clk;

   ysyx_22050133_hazard_ctrl #(.MD_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_wen(id_wen), .ex_muldiv(ex_muldiv), .md_done(md_done),
      .mem_busy(mem_busy), .ex_redirect(ex_redirect), .wb_wen(wb_wen), .wb_rd(wb_rd),
      .has_hazard(has_hazard), .if_stall(if_stall), .id_stall(id_stall),
      .ex_stall(ex_stall), .mem_stall(mem_stall), .if_flush(if_flush),
      .id_flush(id_flush), .md_start(md_start), .mem_bubble(mem_bubble),
      .md_timeout(md_timeout), .pending(pending)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending set as a plain bit array, MDU as phase + wait count.
   logic [31:0] m_pend  = '0;
   int          m_phase = 0;    // 0 idle, 1 waiting on MDU, 2 result parked behind LSU
   int          m_wait  = 0;
   bit          m_start = 1'b0;

   bit          s_haz, s_ifs, s_ids, s_exs, s_mems, s_iff, s_idf, s_bub, s_to, s_start;
   logic [31:0] s_pend;

   task automatic step();
      bit raw, hold, to, exs, haz, fl, iss;
      @(negedge clk);
      raw  = id_valid && (((id_rs1 != 0) && m_pend[id_rs1]) ||
                          ((id_rs2 != 0) && m_pend[id_rs2]) ||
                          (id_wen && (id_rd != 0) && m_pend[id_rd]));
      hold = 1'b0;
      to   = 1'b0;
      if (m_phase == 0) hold = ex_muldiv;
      else if (m_phase == 1 && !md_done) begin
         if (m_wait == T) to = 1'b1;
         else             hold = 1'b1;
      end
      exs = mem_busy || hold;
      haz = raw && !exs && !ex_redirect;
      fl  = ex_redirect && !exs;
      iss = id_valid && !raw && !exs && !ex_redirect;

      s_haz = has_hazard; s_ifs = if_stall; s_ids = id_stall; s_exs = ex_stall;
      s_mems = mem_stall; s_iff = if_flush; s_idf = id_flush; s_bub = mem_bubble;
      s_to = md_timeout; s_start = md_start; s_pend = pending;

      chk("has_hazard", s_haz,   haz);
      chk("if_stall",   s_ifs,   exs || haz);
      chk("id_stall",   s_ids,   exs || haz);
      chk("ex_stall",   s_exs,   exs);
      chk("mem_stall",  s_mems,  mem_busy);
      chk("mem_bubble", s_bub,   exs);
      chk("if_flush",   s_iff,   fl);
      chk("id_flush",   s_idf,   fl);
      chk("md_timeout", s_to,    to && !rst);
      chk("md_start",   s_start, m_start);
      chk("pending",    s_pend,  m_pend);

      @(posedge clk);
      if (rst) begin
         m_pend = '0; m_phase = 0; m_wait = 0; m_start = 1'b0;
      end else begin
         m_start = (m_phase == 0) && ex_muldiv && !mem_busy;
         if (wb_wen) m_pend[wb_rd] = 1'b0;
         if (iss && id_wen && id_rd != 0) m_pend[id_rd] = 1'b1;
         m_pend[0] = 1'b0;
         case (m_phase)
            0: if (ex_muldiv && !mem_busy) begin m_phase = 1; m_wait = 1; end
            1: begin
               if (md_done)  m_phase = mem_busy ? 2 : 0;
               else if (to)  m_phase = 0;
               else          m_wait++;
            end
            default: if (!mem_busy) m_phase = 0;
         endcase
      end
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; id_valid = 1'b0; id_wen = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      ex_muldiv = 1'b0; md_done = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
      wb_wen = 1'b0; wb_rd = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cnt_a, cnt_b, at_a, at_b;
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_pending", s_pend, 32'h0);
      chk("rst_ex_stall", s_exs, 1'b0);

      // RAW on x5 clears only the cycle after its write-back
      idle(); id_valid = 1; id_wen = 1; id_rd = 5; step();
      idle(); id_valid = 1; id_rs1 = 5; step();
      chk("raw_pend5", s_pend[5], 1'b1);
      chk("raw_haz_a", s_haz, 1'b1);
      step();
      chk("raw_haz_b", s_haz, 1'b1);
      wb_wen = 1; wb_rd = 5; step();
      chk("raw_haz_wb", s_haz, 1'b1);
      wb_wen = 0; step();
      chk("raw_haz_clr", s_haz, 1'b0);

      // MDU completing in its 33rd cycle of stall
      idle(); cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 40; i++) begin
         ex_muldiv = (i <= 33);
         md_done   = (i == 33);
         step();
         cnt_a += int'(s_exs);
         cnt_b += int'(s_start);
      end
      chk("md33_stalls", cnt_a, 33);
      chk("md33_starts", cnt_b, 1);
      chk("md33_run", s_exs, 1'b0);

      // Result arriving while LSU busy for 4 cycles
      idle(); cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 13; i++) begin
         ex_muldiv = (i <= 9);
         md_done   = (i == 5);
         mem_busy  = (i >= 5 && i <= 8);
         step();
         cnt_a += int'(s_mems);
         cnt_b += int'(s_exs);
         if (i == 9) chk("hold_release", s_exs, 1'b0);
      end
      chk("hold_memstall", cnt_a, 4);
      chk("hold_exstall", cnt_b, 9);

      // Redirect beats a RAW hazard and issues nothing
      idle(); id_valid = 1; id_wen = 1; id_rd = 3; step();
      idle(); id_valid = 1; id_rs1 = 3; id_wen = 1; id_rd = 9; ex_redirect = 1; step();
      chk("redir_if_flush", s_iff, 1'b1);
      chk("redir_id_flush", s_idf, 1'b1);
      chk("redir_haz", s_haz, 1'b0);
      idle(); step();
      chk("redir_pend", s_pend, 32'h0000_0008);
      wb_wen = 1; wb_rd = 3; step();

      // MDU never answers
      idle(); ex_muldiv = 1; cnt_a = 0; at_a = -1; at_b = -1;
      for (int i = 0; i < 80; i++) begin
         step();
         if (s_start) at_b = i;
         if (s_to) begin cnt_a++; at_a = i; ex_muldiv = 0; end
      end
      chk("to_pulses", cnt_a, 1);
      chk("to_cycle", at_a - at_b + 1, T);
      chk("to_run", s_exs, 1'b0);

      // Same-cycle set/clear of x7, then reset in the middle of MD_WAIT
      idle(); id_valid = 1; id_wen = 1; id_rd = 7; wb_wen = 1; wb_rd = 7; step();
      idle(); step();
      chk("setclr_pend7", s_pend[7], 1'b1);
      ex_muldiv = 1;
      for (int i = 0; i < 6; i++) step();
      rst = 1; ex_muldiv = 0; step();
      chk("rstmid_to", s_to, 1'b0);
      rst = 0; step();
      chk("rstmid_pend", s_pend, 32'h0);
      chk("rstmid_run", s_exs, 1'b0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         id_valid    = ($urandom_range(0, 9) < 7);
         id_wen      = $urandom_range(0, 1);
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         id_rd       = 5'($urandom_range(0, 7));
         ex_muldiv   = ($urandom_range(0, 99) < 8);
         md_done     = ($urandom_range(0, 9) == 0);
         mem_busy    = ($urandom_range(0, 99) < 15);
         ex_redirect = ($urandom_range(0, 9) == 0);
         wb_wen      = ($urandom_range(0, 9) < 4);
         wb_rd       = 5'($urandom_range(0, 7));
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
